// File: rtl/gate_truth_checker.sv
// Stimulus/response checker for the two-input gate block: walks all four {a,b}
// vectors, samples the seven gate responses after SETTLE cycles, and latches a verdict.
module gate_truth_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       and_in,
    input  logic       or_in,
    input  logic       not_in,
    input  logic       nand_in,
    input  logic       nor_in,
    input  logic       xor_in,
    input  logic       xnor_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] fail_mask,
    output logic [3:0] fail_vec,
    output logic [2:0] err_count
);

    localparam logic [7:0] SettleCnt = 8'(SETTLE);

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StHold,
        StFin
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [1:0] stim_q, stim_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pass_q, pass_d;
    logic [6:0] fail_mask_q, fail_mask_d;
    logic [3:0] fail_vec_q, fail_vec_d;
    logic [2:0] err_count_q, err_count_d;

    logic [6:0] resp;
    logic [6:0] expected;
    logic [6:0] mismatch;
    logic       sample_en;
    logic       stim_a;
    logic       stim_b;

    assign stim_a = stim_q[1];
    assign stim_b = stim_q[0];

    // Bit order matches fail_mask: AND, OR, NOT, NAND, NOR, XOR, XNOR from bit 0 up.
    assign resp     = {xnor_in, xor_in, nor_in, nand_in, not_in, or_in, and_in};
    assign expected = {~(stim_a ^ stim_b), stim_a ^ stim_b, ~(stim_a | stim_b),
                       ~(stim_a & stim_b), ~stim_a, stim_a | stim_b, stim_a & stim_b};
    assign mismatch = resp ^ expected;

    // The counter is loaded with SETTLE as the vector is driven; the edge at which it
    // steps 1 -> 0 is exactly SETTLE cycles after the vector appeared on a_out/b_out.
    assign sample_en = ((state_q == StApply) || (state_q == StHold)) && (cnt_q == 8'd1);

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        stim_d      = stim_q;
        cnt_d       = cnt_q;
        pass_d      = pass_q;
        fail_mask_d = fail_mask_q;
        fail_vec_d  = fail_vec_q;
        err_count_d = err_count_q;

        unique case (state_q)
            StIdle: begin
                stim_d = 2'b00;
                if (start) begin
                    state_d     = StApply;
                    vec_d       = 2'd0;
                    stim_d      = 2'b00;
                    cnt_d       = SettleCnt;
                    pass_d      = 1'b0;
                    fail_mask_d = '0;
                    fail_vec_d  = '0;
                    err_count_d = '0;
                end
            end
            StApply: begin
                cnt_d   = cnt_q - 8'd1;
                state_d = StHold;
            end
            StHold: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    stim_d  = vec_q + 2'd1;
                    cnt_d   = SettleCnt;
                    state_d = StApply;
                end else begin
                    stim_d  = 2'b00;
                    pass_d  = (fail_mask_q == 7'd0);
                    state_d = StFin;
                end
            end
            StFin: begin
                stim_d = 2'b00;
                if (start) begin
                    state_d     = StApply;
                    vec_d       = 2'd0;
                    cnt_d       = SettleCnt;
                    pass_d      = 1'b0;
                    fail_mask_d = '0;
                    fail_vec_d  = '0;
                    err_count_d = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                stim_d  = 2'b00;
            end
        endcase

        if (sample_en) begin
            fail_mask_d = fail_mask_q | mismatch;
            if (|mismatch) begin
                fail_vec_d[vec_q] = 1'b1;
                if (err_count_q != 3'd4) begin
                    err_count_d = err_count_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            vec_q       <= 2'd0;
            stim_q      <= 2'b00;
            cnt_q       <= 8'd0;
            pass_q      <= 1'b0;
            fail_mask_q <= '0;
            fail_vec_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            stim_q      <= stim_d;
            cnt_q       <= cnt_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
            fail_vec_q  <= fail_vec_d;
            err_count_q <= err_count_d;
        end
    end

    assign a_out     = stim_q[1];
    assign b_out     = stim_q[0];
    assign busy      = (state_q == StApply) || (state_q == StHold);
    assign done      = (state_q == StFin);
    assign pass      = pass_q;
    assign fail_mask = fail_mask_q;
    assign fail_vec  = fail_vec_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench: a behavioural gate block with fault and pipeline options feeds two
// checkers (SETTLE=2 and SETTLE=1) and their verdicts are compared with hand values.
module tb_gate_truth_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   mode = 0;        // 0 correct, 1 AND stuck at 0, 2 XOR/XNOR swapped
    logic reg_stage = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic       a_out, b_out, busy, done, pass;
    logic [6:0] fail_mask;
    logic [3:0] fail_vec;
    logic [2:0] err_count;
    logic [6:0] resp, resp_q;

    logic       a1, b1, busy1, done1, pass1;
    logic [6:0] fail_mask1;
    logic [3:0] fail_vec1;
    logic [2:0] err_count1;
    logic [6:0] resp1, resp1_q;

    always #5 clk = ~clk;

    function automatic logic [6:0] gate_model(input logic a, input logic b, input int m);
        logic [6:0] r;
        r = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
        if (m == 1) r[0] = 1'b0;
        if (m == 2) r = {r[5], r[6], r[4:0]};
        return r;
    endfunction

    always_ff @(posedge clk) begin
        resp_q  <= gate_model(a_out, b_out, mode);
        resp1_q <= gate_model(a1, b1, mode);
    end

    assign resp  = reg_stage ? resp_q  : gate_model(a_out, b_out, mode);
    assign resp1 = reg_stage ? resp1_q : gate_model(a1, b1, mode);

    gate_truth_checker #(.SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(a_out), .b_out(b_out),
        .and_in(resp[0]), .or_in(resp[1]), .not_in(resp[2]), .nand_in(resp[3]),
        .nor_in(resp[4]), .xor_in(resp[5]), .xnor_in(resp[6]),
        .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask),
        .fail_vec(fail_vec), .err_count(err_count)
    );

    gate_truth_checker #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(a1), .b_out(b1),
        .and_in(resp1[0]), .or_in(resp1[1]), .not_in(resp1[2]), .nand_in(resp1[3]),
        .nor_in(resp1[4]), .xor_in(resp1[5]), .xnor_in(resp1[6]),
        .busy(busy1), .done(done1), .pass(pass1), .fail_mask(fail_mask1),
        .fail_vec(fail_vec1), .err_count(err_count1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller raises start before calling; the first tick is acceptance edge k.
    // Returns in the done cycle (just after edge k+12).
    task automatic do_run(input logic [6:0] e_mask, input logic [3:0] e_vec,
                          input logic [2:0] e_err, input logic e_pass,
                          input logic ign, input logic hold);
        tick();
        if (!hold) start = 1'b0;
        check("busy_at_k", busy, 1);
        check("ab_at_k", {a_out, b_out}, 2'b00);
        check("pass_cleared", pass, 0);
        check("mask_cleared", fail_mask, 0);
        check("vec_cleared", fail_vec, 0);
        for (int i = 1; i <= 12; i++) begin
            if (!hold) start = ign && (i == 4 || i == 8);
            tick();
            check("done_timing", done, (i == 12));
            check("busy_timing", busy, (i < 12));
            if (i == 3) check("ab_v1", {a_out, b_out}, 2'b01);
            if (i == 6) check("ab_v2", {a_out, b_out}, 2'b10);
            if (i == 9) check("ab_v3", {a_out, b_out}, 2'b11);
        end
        if (!hold) start = 1'b0;
        check("ab_fin", {a_out, b_out}, 2'b00);
        check("pass", pass, e_pass);
        check("fail_mask", fail_mask, e_mask);
        check("fail_vec", fail_vec, e_vec);
        check("err_count", err_count, e_err);
    endtask

    initial begin
        #12;
        check("reset_outputs", {a_out, b_out, busy, done, pass, fail_mask, fail_vec, err_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Correct gate model
        start = 1'b1;
        do_run(7'd0, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        tick();
        check("done_one_cycle", done, 0);
        check("results_hold", pass, 1);

        // AND stuck at 0: only v3 expects a 1
        mode = 1;
        start = 1'b1;
        do_run(7'b0000001, 4'b1000, 3'd1, 1'b0, 1'b0, 1'b0);
        tick();

        // XOR/XNOR swapped: every vector fails both
        mode = 2;
        start = 1'b1;
        do_run(7'b1100000, 4'b1111, 3'd4, 1'b0, 1'b0, 1'b0);
        tick();

        // Starts mid-run ignored, then a start in the done cycle restarts with clear results
        mode = 0;
        start = 1'b1;
        do_run(7'd0, 4'd0, 3'd0, 1'b1, 1'b1, 1'b0);
        start = 1'b1;
        do_run(7'd0, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        tick();

        // Start held high: back-to-back runs every 13 cycles
        start = 1'b1;
        do_run(7'd0, 4'd0, 3'd0, 1'b1, 1'b0, 1'b1);
        do_run(7'd0, 4'd0, 3'd0, 1'b1, 1'b0, 1'b1);
        start = 1'b0;
        tick();
        check("idle_after_hold", busy, 0);

        // Reset after the v1 sample: async clear, no done
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("pre_reset_busy", {busy, a_out, b_out}, 3'b110);
        rst_n = 1'b0;
        #1;
        check("async_reset", {a_out, b_out, busy, done, pass, fail_mask, fail_vec, err_count}, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("no_done_in_reset", {done, busy}, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        do_run(7'd0, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        tick();

        // One register stage: SETTLE=2 passes, SETTLE=1 samples the previous vector
        reg_stage = 1'b1;
        repeat (2) tick();
        start = 1'b1;
        do_run(7'd0, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        check("s1_pass", pass1, 0);
        check("s1_fail_mask", fail_mask1, 7'h7F);
        check("s1_fail_vec", fail_vec1, 4'b1110);
        check("s1_err_count", err_count1, 3'd3);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

Self-checking stimulus/response engine for the two-input logic-gate block. On a start request it drives all four `a`/`b` combinations into the gate block and samples the seven gate outputs (AND, OR, NOT-on-A, NAND, NOR, XOR, XNOR) after a programmable settle time. It compares each sample against the expected truth table and reports a pass/fail verdict, a per-gate failure mask and per-vector error flags. It sits on the board/FPGA top level beside the gate block and replaces manual truth-table verification.

## Interface
- `SETTLE`, default 2, range 1..255: number of clock cycles each vector is held before its responses are sampled.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only while `busy`=0.
- `a_out`  out  1  stimulus A to the gate block.
- `b_out`  out  1  stimulus B to the gate block.
- `and_in`, `or_in`, `not_in`, `nand_in`, `nor_in`, `xor_in`, `xnor_in`  in  1 each  gate-block responses.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  1 when the last run had zero mismatches.
- `fail_mask`  out  7  sticky per-gate mismatch flags: bit0 AND, bit1 OR, bit2 NOT, bit3 NAND, bit4 NOR, bit5 XOR, bit6 XNOR.
- `fail_vec`  out  4  bit v set if vector v had any mismatch.
- `err_count`  out  3  number of failing vectors, 0..4.

## Operation
- Vector order: v = {a,b}. v0 = 00, v1 = 01, v2 = 10, v3 = 11.
- Expected values per vector:
  - AND = a&b, OR = a|b, NOT = ~a.
  - NAND = ~(a&b), NOR = ~(a|b).
  - XOR = a^b, XNOR = ~(a^b).
- FSM states:
  - IDLE: `busy`=0, `a_out`=`b_out`=0. If `start`=1, go to APPLY with v=0.
  - APPLY: drive vector v and load the settle counter with SETTLE. Then go to HOLD.
  - HOLD: decrement the counter. When it reaches 0, compare and update results.
    - If v<3: v++ and go to APPLY.
    - Otherwise go to FIN.
  - FIN: assert `done` for one cycle, drive `a_out`/`b_out`=0, then return to IDLE.
- Compare on a vector:
  - OR each per-gate mismatch into `fail_mask`.
  - If any gate mismatches, set `fail_vec[v]` and increment `err_count`, which saturates at 4 (only 4 vectors exist).
- `pass` updates in the FIN cycle to (`fail_mask`==0).
- An accepted `start` clears `pass`, `fail_mask`, `fail_vec` and `err_count` to 0.
- Results hold from FIN until the next accepted start.
- `start` while `busy`=1 is ignored with no queuing. `start` may be held high; each acceptance begins exactly one run.
- `start` in the FIN cycle is accepted: the next cycle is APPLY v0 and results are cleared.

## Timing
- Reset (`rst_n`=0, async): all outputs go to 0 immediately, including `a_out`, `b_out`, `busy`, `done`, `pass`, `fail_mask`, `fail_vec` and `err_count`. State goes to IDLE.
- Reset mid-run: the run is abandoned, no `done` pulse is produced and results are cleared.
- Let start be accepted at edge k:
  - Vector v is driven from edge k+v·(SETTLE+1).
  - Its responses are sampled at edge k+v·(SETTLE+1)+SETTLE.
- `done` is high for the single cycle following edge k+4·(SETTLE+1). With SETTLE=2 that is edge k+12.
- `busy` is high from edge k until `done` rises; it is low in the `done` cycle.
- A response path with d register stages passes only if SETTLE ≥ d+1. A combinational response requires SETTLE ≥ 1.
- Outputs `a_out`/`b_out` are registered, so the checker introduces no combinational path from input to output.

## Test plan
- Correct combinational gate model, SETTLE=2, start pulse at edge k:
  - `a_out`/`b_out` step 00, 01, 10, 11 at edges k, k+3, k+6, k+9.
  - `done` follows edge k+12 with `pass`=1, `fail_mask`=0, `fail_vec`=0, `err_count`=0.
- `and_in` stuck at 0 → `fail_mask`=7'b0000001, `fail_vec`=4'b1000, `err_count`=1, `pass`=0.
- `xor_in`/`xnor_in` swapped → `fail_mask`=7'b1100000, `fail_vec`=4'b1111, `err_count`=4, `pass`=0.
- Start pulses at k+4 and k+8 during a run → ignored, `done` still follows k+12 only.
  - A start in the `done` cycle restarts the run with results cleared.
  - Holding `start` high runs continuously, with a `done` pulse every 13 cycles (SETTLE=2).
- `rst_n` low after the v1 sample → all outputs 0 asynchronously and no `done`.
  - After release, a new start yields `pass`=1 on a correct model.
- Gate model with one register stage:
  - SETTLE=1 → mismatches (`pass`=0).
  - SETTLE=2 → `pass`=1.
